// File: rtl/score_tracker_if.sv
// Score tracker bus: game-logic control inputs and the score/status outputs
// that feed the two-digit score decoder.
interface score_tracker_if;
  logic       start;
  logic       food_eaten;
  logic       game_over;
  logic [7:0] score;
  logic [7:0] high_score;
  logic [7:0] display_score;
  logic       playing;
  logic       saturated;
  logic       new_high;
  logic       show_high;

  // Game logic / stimulus side
  modport master (
    output start, food_eaten, game_over,
    input  score, high_score, display_score, playing, saturated, new_high, show_high
  );

  // Score tracker side
  modport slave (
    input  start, food_eaten, game_over,
    output score, high_score, display_score, playing, saturated, new_high, show_high
  );
endinterface

// File: rtl/score_tracker.sv
// Score tracker: counts food events during a game with saturation, keeps the
// session high score and, after game over, alternates the displayed value
// between the final score and the high score.
module score_tracker #(
  parameter int unsigned MAX_SCORE   = 99,
  parameter int unsigned POINTS      = 1,
  parameter int unsigned SHOW_CYCLES = 50_000_000
) (
  input  logic           clk,
  input  logic           reset_n,
  score_tracker_if.slave bus
);

  localparam int unsigned CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  localparam logic [8:0]       MAX_9    = 9'(MAX_SCORE);
  localparam logic [8:0]       PTS_9    = 9'(POINTS);
  localparam logic [7:0]       MAX_8    = 8'(MAX_SCORE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_OVER    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       score_q, score_d;
  logic [7:0]       high_q, high_d;
  logic             new_high_q, new_high_d;
  logic             show_q, show_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             food_prev_q, food_prev_d;

  logic             eat_s;
  logic [8:0]       sum_s;
  logic [7:0]       score_eat_s;
  logic [7:0]       final_s;

  // Rising-edge detect on food_eaten and the saturating add (9-bit sum never wraps)
  always_comb begin
    eat_s       = bus.food_eaten & ~food_prev_q;
    sum_s       = {1'b0, score_q} + PTS_9;
    score_eat_s = (sum_s > MAX_9) ? MAX_8 : sum_s[7:0];
    final_s     = eat_s ? score_eat_s : score_q;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; start has priority over game_over outside PLAYING
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_PLAYING;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAYING: begin
        if (bus.game_over) begin
          state_d = ST_OVER;
        end else begin
          state_d = ST_PLAYING;
        end
      end
      ST_OVER: begin
        if (bus.start) begin
          state_d = ST_PLAYING;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: score, high score, alternation counter and phase
  always_comb begin
    score_d     = score_q;
    high_d      = high_q;
    new_high_d  = new_high_q;
    show_d      = show_q;
    cnt_d       = cnt_q;
    food_prev_d = bus.food_eaten;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          score_d    = 8'd0;
          new_high_d = 1'b0;
        end else begin
          score_d    = score_q;
          new_high_d = new_high_q;
        end
      end
      ST_PLAYING: begin
        // A same-cycle eat is included in the score compared at game over
        score_d = final_s;
        if (bus.game_over) begin
          if (final_s > high_q) begin
            high_d     = final_s;
            new_high_d = 1'b1;
          end else begin
            high_d     = high_q;
            new_high_d = 1'b0;
          end
          cnt_d  = CNT_ZERO;
          show_d = 1'b0;
        end else begin
          cnt_d  = cnt_q;
          show_d = show_q;
        end
      end
      ST_OVER: begin
        if (bus.start) begin
          score_d    = 8'd0;
          new_high_d = 1'b0;
          show_d     = 1'b0;
          cnt_d      = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d  = CNT_ZERO;
          show_d = ~show_q;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          show_d = show_q;
        end
      end
      default: begin
        score_d = score_q;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_q     <= 8'd0;
      high_q      <= 8'd0;
      new_high_q  <= 1'b0;
      show_q      <= 1'b0;
      cnt_q       <= CNT_ZERO;
      food_prev_q <= 1'b0;
    end else begin
      score_q     <= score_d;
      high_q      <= high_d;
      new_high_q  <= new_high_d;
      show_q      <= show_d;
      cnt_q       <= cnt_d;
      food_prev_q <= food_prev_d;
    end
  end

  // Output decode: status flags and the display mux over registered values
  always_comb begin
    bus.score         = score_q;
    bus.high_score    = high_q;
    bus.new_high      = new_high_q;
    bus.playing       = (state_q == ST_PLAYING);
    bus.saturated     = (score_q == MAX_8);
    bus.show_high     = (state_q == ST_OVER) & show_q;
    bus.display_score = ((state_q == ST_OVER) && show_q) ? high_q : score_q;
  end

endmodule

// File: tb/tb_score_tracker.sv
// Scoreboard bench for score_tracker: two instances (POINTS=1 and POINTS=7)
// share one stimulus stream; a reference model predicts every cycle's outputs.
module tb_score_tracker;

  localparam int MAXS = 99;
  localparam int SHOW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  score_tracker_if bus_a ();
  score_tracker_if bus_b ();

  score_tracker #(.MAX_SCORE(MAXS), .POINTS(1), .SHOW_CYCLES(SHOW)) dut_a (
    .clk(clk), .reset_n(rst_n), .bus(bus_a)
  );
  score_tracker #(.MAX_SCORE(MAXS), .POINTS(7), .SHOW_CYCLES(SHOW)) dut_b (
    .clk(clk), .reset_n(rst_n), .bus(bus_b)
  );

  typedef struct packed {
    logic [7:0] score;
    logic [7:0] high;
    logic [7:0] disp;
    logic       playing;
    logic       sat;
    logic       nh;
    logic       show;
  } exp_t;

  exp_t act_a, act_b;
  assign act_a = {bus_a.score, bus_a.high_score, bus_a.display_score,
                  bus_a.playing, bus_a.saturated, bus_a.new_high, bus_a.show_high};
  assign act_b = {bus_b.score, bus_b.high_score, bus_b.display_score,
                  bus_b.playing, bus_b.saturated, bus_b.new_high, bus_b.show_high};

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 = idle, 1 = playing, 2 = game over
  int m_mode [2];
  int m_score[2];
  int m_high [2];
  int m_cnt  [2];
  bit m_nh   [2];
  bit m_show [2];
  bit m_prev [2];
  int pts    [2] = '{1, 7};

  exp_t q0[$];
  exp_t q1[$];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_score[d] = 0; m_high[d] = 0; m_cnt[d] = 0;
      m_nh[d] = 1'b0; m_show[d] = 1'b0; m_prev[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input bit s, input bit f, input bit g);
    bit eat;
    eat = f && !m_prev[d];
    m_prev[d] = f;
    if (m_mode[d] == 0) begin
      if (s) begin
        m_mode[d] = 1; m_score[d] = 0; m_nh[d] = 1'b0;
      end
    end else if (m_mode[d] == 1) begin
      if (eat) m_score[d] = (m_score[d] + pts[d] > MAXS) ? MAXS : m_score[d] + pts[d];
      if (g) begin
        m_mode[d] = 2;
        if (m_score[d] > m_high[d]) begin
          m_high[d] = m_score[d]; m_nh[d] = 1'b1;
        end else begin
          m_nh[d] = 1'b0;
        end
        m_cnt[d] = 0; m_show[d] = 1'b0;
      end
    end else begin
      if (s) begin
        m_mode[d] = 1; m_score[d] = 0; m_nh[d] = 1'b0; m_show[d] = 1'b0; m_cnt[d] = 0;
      end else if (m_cnt[d] == SHOW - 1) begin
        m_cnt[d] = 0; m_show[d] = !m_show[d];
      end else begin
        m_cnt[d] = m_cnt[d] + 1;
      end
    end
  endtask

  function automatic exp_t model_out(input int d);
    exp_t e;
    e.score   = 8'(m_score[d]);
    e.high    = 8'(m_high[d]);
    e.disp    = (m_mode[d] == 2 && m_show[d]) ? 8'(m_high[d]) : 8'(m_score[d]);
    e.playing = (m_mode[d] == 1);
    e.sat     = (m_score[d] == MAXS);
    e.nh      = m_nh[d];
    e.show    = (m_mode[d] == 2) && m_show[d];
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp(input string name, input exp_t a, input exp_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0t got score=%0d high=%0d disp=%0d play=%0b sat=%0b nh=%0b show=%0b expected score=%0d high=%0d disp=%0d play=%0b sat=%0b nh=%0b show=%0b",
               name, $time, a.score, a.high, a.disp, a.playing, a.sat, a.nh, a.show,
               e.score, e.high, e.disp, e.playing, e.sat, e.nh, e.show);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, predict the next rising edge
  task automatic cycle(input bit s, input bit f, input bit g);
    @(negedge clk);
    bus_a.start = s; bus_a.food_eaten = f; bus_a.game_over = g;
    bus_b.start = s; bus_b.food_eaten = f; bus_b.game_over = g;
    model_step(0, s, f, g);
    model_step(1, s, f, g);
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
  endtask

  task automatic pulse();
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any clock edge
  task automatic mid_reset();
    @(posedge clk);
    #3;
    bus_a.start = 1'b0; bus_a.food_eaten = 1'b0; bus_a.game_over = 1'b0;
    bus_b.start = 1'b0; bus_b.food_eaten = 1'b0; bus_b.game_over = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", int'(act_a), 0);
    chk("async_rst_b", int'(act_b), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: after every rising edge pop the prediction and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp("sb_a", act_a, e);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp("sb_b", act_b, e);
      end
    end
  end

  // Stimulus
  initial begin
    bus_a.start = 1'b0; bus_a.food_eaten = 1'b0; bus_a.game_over = 1'b0;
    bus_b.start = 1'b0; bus_b.food_eaten = 1'b0; bus_b.game_over = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_a", int'(act_a), 0);
    chk("reset_b", int'(act_b), 0);
    rst_n = 1'b1;

    // Game 1: five separate eats, then game over sets a new high
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    repeat (5) pulse();
    chk("g1_score_a", int'(bus_a.score), 5);
    chk("g1_playing_a", int'(bus_a.playing), 1);
    chk("g1_score_b", int'(bus_b.score), 35);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    chk("g1_high_a", int'(bus_a.high_score), 5);
    chk("g1_newhigh_a", int'(bus_a.new_high), 1);
    chk("g1_over_playing_a", int'(bus_a.playing), 0);

    // Game 2: a 20-cycle held level counts once; final 3 does not beat 5
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("hold_once_a", int'(bus_a.score), 1);
    chk("hold_once_b", int'(bus_b.score), 7);
    repeat (2) pulse();
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      chk("alt_disp_a", int'(bus_a.display_score), ((i / 4) % 2 == 0) ? 3 : 5);
      chk("alt_show_a", int'(bus_a.show_high), ((i / 4) % 2 == 0) ? 0 : 1);
    end
    chk("g2_high_a", int'(bus_a.high_score), 5);
    chk("g2_newhigh_a", int'(bus_a.new_high), 0);

    // Game 3: eat and game over in the same cycle at score 4
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    repeat (4) pulse();
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    chk("same_cycle_score_a", int'(bus_a.score), 5);
    chk("same_cycle_high_a", int'(bus_a.high_score), 5);
    chk("same_cycle_nh_a", int'(bus_a.new_high), 0);
    chk("same_cycle_score_b", int'(bus_b.score), 35);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Reset in the middle of the alternation, then a fresh game
    mid_reset();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("post_rst_playing_a", int'(bus_a.playing), 1);
    chk("post_rst_score_a", int'(bus_a.score), 0);

    // Saturation: POINTS=7 reaches 98 after 14 eats then clamps at 99
    repeat (14) pulse();
    chk("sat_98_b", int'(bus_b.score), 98);
    chk("sat_98_flag_b", int'(bus_b.saturated), 0);
    pulse();
    chk("sat_99_b", int'(bus_b.score), 99);
    chk("sat_flag_b", int'(bus_b.saturated), 1);
    pulse();
    chk("sat_hold_b", int'(bus_b.score), 99);
    chk("sat_a", int'(bus_a.score), 16);
    cycle(1'b0, 1'b0, 1'b1);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0);
    end
    cycle(1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    chk("drain_a", q0.size(), 0);
    chk("drain_b", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_tracker.md
Name: score_tracker

Overview:
- Game-side score keeper for the snake design; sits directly upstream of the two-digit 7-segment score decoder and drives its 8-bit score input.
- Counts food-eaten events during a game, saturates at the two-digit display limit and keeps a session high score.
- After game over, the display value alternates between the final score and the high score.

Parameters:
- MAX_SCORE, 99: saturation ceiling for score. Must be ≤ 99 so the downstream decoder's two digits can show it.
- POINTS, 1: amount added per food event. Range 1..MAX_SCORE.
- SHOW_CYCLES, 50_000_000: clock cycles spent on each half of the game-over alternation. Must be ≥ 1.

Ports:
- clk  input  1  system clock, rising-edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  level, sampled each cycle; begins a new game
- food_eaten  input  1  level from game logic; each rising edge counts once
- game_over  input  1  level, sampled each cycle; ends the current game
- score  output  8  current game score, registered, 0..MAX_SCORE
- high_score  output  8  best final score since reset, registered
- display_score  output  8  value for the score decoder; combinational mux of registered values
- playing  output  1  high while the FSM is in PLAYING
- saturated  output  1  high when score == MAX_SCORE
- new_high  output  1  high when the last game set a new high score; registered
- show_high  output  1  in OVER, high while display_score shows high_score

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE. score, high_score, new_high, show_high, alternation counter and food_prev all 0. Outputs settle immediately, without waiting for a clock edge.
- Edge detect:
  - food_prev <= food_eaten every cycle.
  - eat = food_eaten & ~food_prev.
  - A level held for many cycles counts exactly once.
- FSM states: IDLE, PLAYING, OVER.
- IDLE:
  - display_score = score.
  - start=1 → PLAYING; score <= 0, new_high <= 0.
  - eat and game_over are ignored.
- PLAYING:
  - eat=1 → score <= min(score+POINTS, MAX_SCORE). Compute the sum 9 bits wide so it never wraps.
  - At MAX_SCORE, further eats leave score unchanged.
  - game_over=1 → OVER.
  - start is ignored.
  - Score latency: food_eaten rising at edge N gives the updated score visible after edge N (1 cycle).
- PLAYING→OVER transition cycle:
  - Let final = the score value being written that cycle; it includes a same-cycle eat.
  - If final > high_score: high_score <= final and new_high <= 1. Otherwise new_high <= 0.
  - Equal to high_score is not a new high.
  - Counter <= 0, show_high <= 0.
- OVER:
  - Counter increments each cycle.
  - When counter == SHOW_CYCLES-1: counter <= 0 and show_high toggles.
  - display_score = show_high ? high_score : score.
  - eat and game_over are ignored.
  - start=1 → PLAYING; score <= 0, new_high <= 0, show_high <= 0, counter <= 0. high_score is retained.
- Simultaneous events:
  - start+game_over in IDLE or OVER: start wins.
  - eat+game_over in PLAYING: eat counted, then the transition.
- Outside OVER: show_high = 0 and display_score = score.
- saturated = (score == MAX_SCORE) in all states.
- playing = (state == PLAYING).
- Reset mid-game or mid-alternation: everything returns to reset values, including high_score.

Test Plan:
- Reset, start, then 5 separate food_eaten pulses → score=5 and playing=1. Next game_over → high_score=5, new_high=1, state OVER.
- Hold food_eaten high for 20 cycles while PLAYING → score increments by exactly 1.
- MAX_SCORE=99, POINTS=7, 15 eats → score goes 98 then 99 (not 105 or a wrapped value), and saturated=1.
- Second game, 3 eats then game_over, with high_score=5 → high_score stays 5 and new_high=0. With SHOW_CYCLES=4: display_score=3 for 4 cycles, then 5 for 4 cycles, repeating; show_high tracks the alternation.
- eat and game_over in the same cycle at score=4 → final score 5 is captured and compared against high_score.
- Assert reset_n low mid-OVER with high_score=5, no clock edge → all outputs read 0 immediately. After release, start → PLAYING with score=0.
